dm_sba: RTL and testbench

DM_SBA -- requirements
Module: dm_sba

---
 rtl/dm_sba_if.sv | 30 +++
 rtl/dm_sba.sv | 180 ++++++++++++++++++
 tb/tb_dm_sba.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sba_if.sv
// DMI register-access port and system-bus master port of the debug-module system bus access block.
interface dm_sba_if;
    logic        dmi_valid;
    logic [6:0]  dmi_addr;
    logic        dmi_wr;
    logic [31:0] dmi_wdata;
    logic [31:0] dmi_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    // master is the SBA block itself: it serves DMI accesses and masters the system bus
    modport master (
        input  dmi_valid, dmi_addr, dmi_wr, dmi_wdata,
        output dmi_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        output dmi_valid, dmi_addr, dmi_wr, dmi_wdata,
        input  dmi_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/dm_sba.sv
// Debug-module system bus access: sbcs/sbaddress0/sbdata0 registers and a 32-bit bus master FSM
// with busy/bus-error/size-error/timeout reporting.
module dm_sba #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     dmactive,
    dm_sba_if.master sba
);
    localparam logic [6:0] ADDR_SBCS   = 7'h38;
    localparam logic [6:0] ADDR_SBADDR = 7'h39;
    localparam logic [6:0] ADDR_SBDATA = 7'h3C;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e           r_state;
    logic             r_bus_req;
    logic             r_bus_we;
    logic [31:0]      r_bus_addr;
    logic [31:0]      r_bus_wdata;
    logic [31:0]      r_sbaddress;
    logic [31:0]      r_sbdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sbbusyerror;
    logic             r_sbreadonaddr;
    logic [2:0]       r_sbaccess;
    logic             r_sbautoincrement;
    logic             r_sbreadondata;
    logic [2:0]       r_sberror;

    logic        w_busy;
    logic [31:0] w_sbcs;
    logic        w_wr_sbcs;
    logic        w_wr_addr;
    logic        w_wr_data;
    logic        w_rd_data;
    logic        w_start_req;
    logic        w_start;
    logic        w_bad_size;
    logic        w_busy_hit;
    logic        w_ack;
    logic        w_timeout;
    logic [2:0]  w_sberror_nxt;
    logic        w_sbbusyerror_nxt;

    assign w_busy = (r_state == StBusy);
    assign w_sbcs = {3'd1, 6'd0, r_sbbusyerror, w_busy, r_sbreadonaddr, r_sbaccess,
                     r_sbautoincrement, r_sbreadondata, r_sberror, 7'd32, 5'b00100};

    assign w_wr_sbcs = sba.dmi_valid && sba.dmi_wr && (sba.dmi_addr == ADDR_SBCS);
    assign w_wr_addr = sba.dmi_valid && sba.dmi_wr && (sba.dmi_addr == ADDR_SBADDR);
    assign w_wr_data = sba.dmi_valid && sba.dmi_wr && (sba.dmi_addr == ADDR_SBDATA);
    assign w_rd_data = sba.dmi_valid && !sba.dmi_wr && (sba.dmi_addr == ADDR_SBDATA);

    assign w_start_req = !w_busy && (r_sberror == 3'd0) && !r_sbbusyerror &&
                         ((w_wr_addr && r_sbreadonaddr) || w_wr_data ||
                          (w_rd_data && r_sbreadondata));
    assign w_start    = w_start_req && (r_sbaccess == 3'd2);
    assign w_bad_size = w_start_req && (r_sbaccess != 3'd2);
    assign w_busy_hit = w_busy && (w_wr_addr || w_wr_data || w_rd_data);
    assign w_ack      = w_busy && sba.bus_ack;
    assign w_timeout  = w_busy && !sba.bus_ack && (r_cnt == CNT_LAST);

    // Error sets are applied after the W1C clear so a same-cycle set survives the clear.
    always_comb begin
        w_sberror_nxt = r_sberror;
        if (w_wr_sbcs) begin
            w_sberror_nxt = r_sberror & ~sba.dmi_wdata[14:12];
        end
        if (w_ack && sba.bus_err) begin
            w_sberror_nxt = 3'd2;
        end else if (w_timeout) begin
            w_sberror_nxt = 3'd1;
        end else if (w_bad_size) begin
            w_sberror_nxt = 3'd4;
        end
    end

    assign w_sbbusyerror_nxt = (r_sbbusyerror && !(w_wr_sbcs && sba.dmi_wdata[22])) || w_busy_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_bus_req         <= 1'b0;
            r_bus_we          <= 1'b0;
            r_bus_addr        <= 32'd0;
            r_bus_wdata       <= 32'd0;
            r_sbaddress       <= 32'd0;
            r_sbdata          <= 32'd0;
            r_cnt             <= '0;
            r_sbbusyerror     <= 1'b0;
            r_sbreadonaddr    <= 1'b0;
            r_sbaccess        <= 3'd2;
            r_sbautoincrement <= 1'b0;
            r_sbreadondata    <= 1'b0;
            r_sberror         <= 3'd0;
        end else if (!dmactive) begin
            r_state           <= StIdle;
            r_bus_req         <= 1'b0;
            r_bus_we          <= 1'b0;
            r_bus_addr        <= 32'd0;
            r_bus_wdata       <= 32'd0;
            r_sbaddress       <= 32'd0;
            r_sbdata          <= 32'd0;
            r_cnt             <= '0;
            r_sbbusyerror     <= 1'b0;
            r_sbreadonaddr    <= 1'b0;
            r_sbaccess        <= 3'd2;
            r_sbautoincrement <= 1'b0;
            r_sbreadondata    <= 1'b0;
            r_sberror         <= 3'd0;
        end else begin
            r_sberror     <= w_sberror_nxt;
            r_sbbusyerror <= w_sbbusyerror_nxt;
            if (w_wr_sbcs) begin
                r_sbreadonaddr    <= sba.dmi_wdata[20];
                r_sbaccess        <= sba.dmi_wdata[19:17];
                r_sbautoincrement <= sba.dmi_wdata[16];
                r_sbreadondata    <= sba.dmi_wdata[15];
            end
            case (r_state)
                StIdle: begin
                    if (w_wr_addr) begin
                        r_sbaddress <= sba.dmi_wdata;
                    end
                    if (w_wr_data) begin
                        r_sbdata <= sba.dmi_wdata;
                    end
                    if (w_start) begin
                        r_state     <= StBusy;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_wr_data;
                        r_bus_addr  <= w_wr_addr ? sba.dmi_wdata : r_sbaddress;
                        r_bus_wdata <= w_wr_data ? sba.dmi_wdata : r_sbdata;
                        r_cnt       <= '0;
                    end
                end
                StBusy: begin
                    if (sba.bus_ack) begin
                        r_state   <= StIdle;
                        r_bus_req <= 1'b0;
                        if (!sba.bus_err) begin
                            if (!r_bus_we) begin
                                r_sbdata <= sba.bus_rdata;
                            end
                            if (r_sbautoincrement) begin
                                r_sbaddress <= r_sbaddress + 32'd4;
                            end
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_state   <= StIdle;
                        r_bus_req <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // dmactive gates the request combinationally so it falls in the same cycle.
    assign sba.bus_req   = r_bus_req && dmactive;
    assign sba.bus_we    = r_bus_we;
    assign sba.bus_addr  = r_bus_addr;
    assign sba.bus_wdata = r_bus_wdata;

    always_comb begin
        sba.dmi_rdata = 32'd0;
        case (sba.dmi_addr)
            ADDR_SBCS:   sba.dmi_rdata = w_sbcs;
            ADDR_SBADDR: sba.dmi_rdata = r_sbaddress;
            ADDR_SBDATA: sba.dmi_rdata = r_sbdata;
            default:     sba.dmi_rdata = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_dm_sba.sv
// Directed bench for dm_sba: a register-access vector table followed by hand-written
// bus-access sequences (write, auto-increment read, busy, errors, timeout, resets).
module tb_dm_sba;
    logic clk;
    logic rst_n;
    logic dmactive;
    int   n_tests;
    int   n_fail;

    dm_sba_if sba_if ();

    dm_sba #(
        .TIMEOUT(255)
    ) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dmactive(dmactive),
        .sba     (sba_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        sba_if.dmi_valid = 1'b1;
        sba_if.dmi_wr    = 1'b1;
        sba_if.dmi_addr  = a;
        sba_if.dmi_wdata = d;
        @(posedge clk);
        #1;
        sba_if.dmi_valid = 1'b0;
        sba_if.dmi_wr    = 1'b0;
    endtask

    task automatic dmi_read(input logic [6:0] a, output logic [31:0] d);
        sba_if.dmi_valid = 1'b1;
        sba_if.dmi_wr    = 1'b0;
        sba_if.dmi_addr  = a;
        #1;
        d = sba_if.dmi_rdata;
        @(posedge clk);
        #1;
        sba_if.dmi_valid = 1'b0;
    endtask

    // Side-effect-free look at a register (dmi_valid low).
    task automatic peek(input logic [6:0] a, output logic [31:0] d);
        sba_if.dmi_valid = 1'b0;
        sba_if.dmi_addr  = a;
        #1;
        d = sba_if.dmi_rdata;
    endtask

    // Bus slave: acks on the ack_at-th request cycle (0 = never); bounded at 400 cycles.
    task automatic serve(input int ack_at, input logic err, input logic [31:0] rd,
                         output int n_high, output int n_unstable);
        logic        we0;
        logic [31:0] a0;
        logic [31:0] d0;
        n_high     = 0;
        n_unstable = 0;
        we0 = sba_if.bus_we;
        a0  = sba_if.bus_addr;
        d0  = sba_if.bus_wdata;
        for (int i = 0; i < 400; i++) begin
            if (!sba_if.bus_req) break;
            n_high++;
            if (sba_if.bus_we !== we0 || sba_if.bus_addr !== a0 || sba_if.bus_wdata !== d0) begin
                n_unstable++;
            end
            if (n_high == ack_at) begin
                sba_if.bus_ack   = 1'b1;
                sba_if.bus_err   = err;
                sba_if.bus_rdata = rd;
            end
            @(posedge clk);
            #1;
            sba_if.bus_ack = 1'b0;
            sba_if.bus_err = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          nh;
        int          nu;
        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{1'b0, 7'h38, 32'h0000_0000, 32'h2004_0404};
        vecs[1]  = '{1'b0, 7'h39, 32'h0000_0000, 32'h0000_0000};
        vecs[2]  = '{1'b0, 7'h3C, 32'h0000_0000, 32'h0000_0000};
        vecs[3]  = '{1'b0, 7'h10, 32'h0000_0000, 32'h0000_0000};
        vecs[4]  = '{1'b1, 7'h39, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[5]  = '{1'b0, 7'h39, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 7'h10, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[7]  = '{1'b0, 7'h39, 32'h0000_0000, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 7'h38, 32'hE001_8FFF, 32'h0000_0000};
        vecs[9]  = '{1'b0, 7'h38, 32'h0000_0000, 32'h2001_8404};
        vecs[10] = '{1'b0, 7'h3C, 32'h0000_0000, 32'h0000_0000};
        vecs[11] = '{1'b0, 7'h38, 32'h0000_0000, 32'h2001_C404};
        vecs[12] = '{1'b1, 7'h38, 32'h0004_7000, 32'h0000_0000};
        vecs[13] = '{1'b0, 7'h38, 32'h0000_0000, 32'h2004_0404};

        rst_n            = 1'b0;
        dmactive         = 1'b1;
        sba_if.dmi_valid = 1'b0;
        sba_if.dmi_wr    = 1'b0;
        sba_if.dmi_addr  = 7'h0;
        sba_if.dmi_wdata = 32'h0;
        sba_if.bus_ack   = 1'b0;
        sba_if.bus_err   = 1'b0;
        sba_if.bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_bus_req", {31'd0, sba_if.bus_req}, 32'd0);
        check("reset_bus_addr", sba_if.bus_addr, 32'd0);

        // Register-access table: reads compare dmi_rdata, every row checks no bus request.
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                dmi_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                dmi_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
            check($sformatf("vec%0d_no_req", i), {31'd0, sba_if.bus_req}, 32'd0);
        end

        // Plain write, acked on the third request cycle.
        dmi_write(7'h39, 32'h0000_1000);
        dmi_write(7'h3C, 32'hDEAD_BEEF);
        check("wr_we", {31'd0, sba_if.bus_we}, 32'd1);
        check("wr_addr", sba_if.bus_addr, 32'h0000_1000);
        check("wr_wdata", sba_if.bus_wdata, 32'hDEAD_BEEF);
        peek(7'h38, rd);
        check("wr_sbbusy_high", rd, 32'h2024_0404);
        serve(3, 1'b0, 32'h0, nh, nu);
        check("wr_req_cycles", nh, 3);
        check("wr_stable", nu, 0);
        peek(7'h38, rd);
        check("wr_sbbusy_low", rd, 32'h2004_0404);

        // Read on address with auto-increment, then address wrap.
        dmi_write(7'h38, 32'h0015_0000);
        dmi_write(7'h39, 32'h0000_2000);
        check("rd_we", {31'd0, sba_if.bus_we}, 32'd0);
        check("rd_addr", sba_if.bus_addr, 32'h0000_2000);
        serve(2, 1'b0, 32'h1234_5678, nh, nu);
        check("rd_req_cycles", nh, 2);
        peek(7'h3C, rd);
        check("rd_sbdata", rd, 32'h1234_5678);
        peek(7'h39, rd);
        check("rd_autoinc", rd, 32'h0000_2004);
        dmi_write(7'h39, 32'hFFFF_FFFC);
        serve(1, 1'b0, 32'hA5A5_A5A5, nh, nu);
        peek(7'h39, rd);
        check("rd_wrap", rd, 32'h0000_0000);
        peek(7'h3C, rd);
        check("rd_wrap_data", rd, 32'hA5A5_A5A5);
        dmi_write(7'h38, 32'h0004_0000);

        // Busy: data write during an access is refused and flagged.
        dmi_write(7'h3C, 32'h1111_1111);
        dmi_write(7'h3C, 32'h2222_2222);
        peek(7'h38, rd);
        check("busy_err_set", rd, 32'h2064_0404);
        peek(7'h3C, rd);
        check("busy_data_kept", rd, 32'h1111_1111);
        serve(1, 1'b0, 32'h0, nh, nu);
        check("busy_wdata_kept", sba_if.bus_wdata, 32'h1111_1111);
        dmi_write(7'h3C, 32'h3333_3333);
        check("busy_blocks_start", {31'd0, sba_if.bus_req}, 32'd0);
        dmi_write(7'h38, 32'h0044_0000);
        peek(7'h38, rd);
        check("busy_err_cleared", rd, 32'h2004_0404);
        dmi_write(7'h3C, 32'h4444_4444);
        check("busy_after_clear_req", {31'd0, sba_if.bus_req}, 32'd1);
        check("busy_after_clear_wdata", sba_if.bus_wdata, 32'h4444_4444);
        serve(1, 1'b0, 32'h0, nh, nu);

        // Bus error, blocking, clear via 0x7000 (which also zeroes sbaccess), bad size.
        dmi_write(7'h39, 32'h0000_3000);
        dmi_write(7'h3C, 32'h5555_5555);
        serve(2, 1'b1, 32'hBAD0_BAD0, nh, nu);
        peek(7'h38, rd);
        check("buserr_sberror", rd, 32'h2004_2404);
        peek(7'h3C, rd);
        check("buserr_data_kept", rd, 32'h5555_5555);
        dmi_write(7'h3C, 32'h6666_6666);
        check("buserr_blocks", {31'd0, sba_if.bus_req}, 32'd0);
        dmi_write(7'h38, 32'h0000_7000);
        peek(7'h38, rd);
        check("buserr_cleared", rd, 32'h2000_0404);
        dmi_write(7'h3C, 32'h7777_7777);
        check("badsize_no_req", {31'd0, sba_if.bus_req}, 32'd0);
        peek(7'h38, rd);
        check("badsize_sberror", rd, 32'h2000_4404);
        dmi_write(7'h38, 32'h0004_7000);

        // Same-cycle error set beats the clearing write.
        dmi_write(7'h3C, 32'h8888_8888);
        sba_if.bus_ack = 1'b1;
        sba_if.bus_err = 1'b1;
        dmi_write(7'h38, 32'h0004_7000);
        sba_if.bus_ack = 1'b0;
        sba_if.bus_err = 1'b0;
        peek(7'h38, rd);
        check("clear_vs_set", rd, 32'h2004_2404);
        dmi_write(7'h38, 32'h0004_7000);

        // Timeout: no ack at all.
        dmi_write(7'h3C, 32'h9999_9999);
        serve(0, 1'b0, 32'h0, nh, nu);
        check("timeout_cycles", nh, 255);
        peek(7'h38, rd);
        check("timeout_sberror", rd, 32'h2004_1404);
        dmi_write(7'h38, 32'h0004_7000);

        // dmactive low mid-access: request drops at once, late ack ignored, state reset.
        dmi_write(7'h39, 32'h0000_4000);
        dmi_write(7'h38, 32'h0005_0000);
        dmi_write(7'h3C, 32'hABCD_0123);
        dmactive         = 1'b0;
        sba_if.bus_ack   = 1'b1;
        sba_if.bus_rdata = 32'h0;
        #1;
        check("dmactive_req_drop", {31'd0, sba_if.bus_req}, 32'd0);
        @(posedge clk);
        #1;
        sba_if.bus_ack = 1'b0;
        dmactive       = 1'b1;
        peek(7'h38, rd);
        check("dmactive_sbcs", rd, 32'h2004_0404);
        peek(7'h39, rd);
        check("dmactive_sbaddr", rd, 32'h0000_0000);
        peek(7'h3C, rd);
        check("dmactive_sbdata", rd, 32'h0000_0000);
        check("dmactive_bus_addr", sba_if.bus_addr, 32'h0000_0000);

        // Asynchronous reset mid-access.
        dmi_write(7'h38, 32'h0015_0000);
        dmi_write(7'h39, 32'h0000_5000);
        check("rst_mid_req_high", {31'd0, sba_if.bus_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_req_drop", {31'd0, sba_if.bus_req}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        peek(7'h38, rd);
        check("rst_mid_sbcs", rd, 32'h2004_0404);
        peek(7'h39, rd);
        check("rst_mid_sbaddr", rd, 32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
